// File: rtl/cond_pp_pkg.sv
// Shared types for the conditional-compilation sequencer.
//   tok_kind_e    : lexed token kinds as they arrive on tok_kind
//   err_e         : error codes reported on out_err
//   stack_entry_t : one nesting level {par, taken, in_else}
//   state_e       : RUN / ERR sequencer state
package cond_pp_pkg;

  typedef enum logic [3:0] {
    TK_TEXT   = 4'd0,
    TK_IFDEF  = 4'd1,
    TK_IFNDEF = 4'd2,
    TK_ELSIF  = 4'd3,
    TK_ELSE   = 4'd4,
    TK_ENDIF  = 4'd5,
    TK_DEFINE = 4'd6,
    TK_UNDEF  = 4'd7,
    TK_EOF    = 4'd8
  } tok_kind_e;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_OVF     = 3'd1,
    ERR_UNF     = 3'd2,
    ERR_ORDER   = 3'd3,
    ERR_UNTERM  = 3'd4
  } err_e;

  // par: enclosing region active; taken: some branch already selected;
  // in_else: the else arm has been entered.
  typedef struct packed {
    logic par;
    logic taken;
    logic in_else;
  } stack_entry_t;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_ERR = 1'b1
  } state_e;

endpackage

// File: rtl/cond_directive_sequencer_if.sv
// Token stream bundle for the sequencer.
//   tok_valid/tok_ready/tok_kind/tok_id : input token handshake
//   clr_defs                            : clear-table pulse
//   out_valid/out_ready/out_kind/out_id : output token handshake
//   out_active/out_err                  : per-token tags
// master drives tokens and out_ready; slave is the sequencer.
interface cond_directive_sequencer_if #(
  parameter int ID_W = 6
);
  logic            tok_valid;
  logic            tok_ready;
  logic [3:0]      tok_kind;
  logic [ID_W-1:0] tok_id;
  logic            clr_defs;
  logic            out_valid;
  logic            out_ready;
  logic [3:0]      out_kind;
  logic [ID_W-1:0] out_id;
  logic            out_active;
  logic [2:0]      out_err;

  modport master (
    output tok_valid, tok_kind, tok_id, clr_defs, out_ready,
    input  tok_ready, out_valid, out_kind, out_id, out_active, out_err
  );

  modport slave (
    input  tok_valid, tok_kind, tok_id, clr_defs, out_ready,
    output tok_ready, out_valid, out_kind, out_id, out_active, out_err
  );
endinterface

// File: rtl/cond_stack.sv
// LIFO of nesting entries with push, pop, in-place top modify and clear.
//   clk, rst_n      : clock, async active-low reset (depth only)
//   push/push_e     : push a new entry
//   pop             : drop the top entry
//   modify/mod_e    : overwrite the top entry
//   clear           : empty the stack
//   top             : current top entry (undefined when depth == 0)
//   depth           : number of valid entries
module cond_stack
  import cond_pp_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       modify,
  input  logic                       clear,
  input  stack_entry_t               push_e,
  input  stack_entry_t               mod_e,
  output stack_entry_t               top,
  output logic [$clog2(DEPTH+1)-1:0] depth
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW = $clog2(DEPTH+1);

  stack_entry_t mem [DEPTH];
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] top_idx;

  assign wr_idx  = AW'(depth);
  assign top_idx = AW'(depth - DW'(1));
  assign top     = mem[top_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth <= '0;
    end else if (clear) begin
      depth <= '0;
    end else if (push) begin
      depth <= depth + DW'(1);
    end else if (pop) begin
      depth <= depth - DW'(1);
    end
  end

  // Entry storage carries no reset; depth alone defines validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_idx] <= push_e;
    end else if (modify) begin
      mem[top_idx] <= mod_e;
    end
  end

endmodule

// File: rtl/cond_directive_sequencer.sv
// Conditional-compilation sequencer: tags each lexed token with an active
// flag, tracks `ifdef nesting and the macro-defined table.
//   clk, rst_n : clock, async active-low reset
//   bus        : token stream (slave modport)
//   depth      : current nesting depth
// One output register stage; a token accepted on one edge is presented on
// out_* after that edge and held while out_ready is low.
module cond_directive_sequencer
  import cond_pp_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int ID_W  = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  cond_directive_sequencer_if.slave    bus,
  output logic [$clog2(DEPTH+1)-1:0]   depth
);
  localparam int DW = $clog2(DEPTH+1);

  state_e             state;
  state_e             nxt_state;
  logic               cur_active;
  logic               nxt_active;
  logic [2**ID_W-1:0] tbl;
  logic               accept;
  tok_kind_e          kind;
  logic               cond_bit;
  logic               ifcond;
  stack_entry_t       top;
  stack_entry_t       push_e;
  stack_entry_t       mod_e;
  logic               push;
  logic               pop;
  logic               modify;
  logic               clear;
  logic               o_active;
  err_e               o_err;

  assign bus.tok_ready = !bus.out_valid | bus.out_ready;
  assign accept        = bus.tok_valid & bus.tok_ready;
  assign kind          = tok_kind_e'(bus.tok_kind);
  assign cond_bit      = tbl[bus.tok_id];
  assign ifcond        = (kind == TK_IFNDEF) ? !cond_bit : cond_bit;

  cond_stack #(.DEPTH(DEPTH)) u_stack (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .pop    (pop),
    .modify (modify),
    .clear  (clear),
    .push_e (push_e),
    .mod_e  (mod_e),
    .top    (top),
    .depth  (depth)
  );

  // Decode of the accepted token against the current state.
  always_comb begin
    push       = 1'b0;
    pop        = 1'b0;
    modify     = 1'b0;
    clear      = 1'b0;
    push_e     = '{par: cur_active, taken: ifcond, in_else: 1'b0};
    mod_e      = top;
    nxt_active = cur_active;
    nxt_state  = state;
    o_active   = 1'b0;
    o_err      = ERR_NONE;
    if (accept) begin
      if (kind == TK_EOF) begin
        o_active   = 1'b1;
        o_err      = (depth != '0) ? ERR_UNTERM : ERR_NONE;
        clear      = 1'b1;
        nxt_active = 1'b1;
        nxt_state  = ST_RUN;
      end else if (state == ST_RUN) begin
        case (kind)
          TK_IFDEF, TK_IFNDEF: begin
            if (depth == DW'(DEPTH)) begin
              o_err     = ERR_OVF;
              nxt_state = ST_ERR;
            end else begin
              push       = 1'b1;
              nxt_active = cur_active & ifcond;
            end
          end
          TK_ELSIF: begin
            if (depth == '0) begin
              o_err     = ERR_UNF;
              nxt_state = ST_ERR;
            end else if (top.in_else) begin
              o_err     = ERR_ORDER;
              nxt_state = ST_ERR;
            end else begin
              modify      = 1'b1;
              mod_e.taken = top.taken | cond_bit;
              nxt_active  = top.par & !top.taken & cond_bit;
            end
          end
          TK_ELSE: begin
            if (depth == '0) begin
              o_err     = ERR_UNF;
              nxt_state = ST_ERR;
            end else if (top.in_else) begin
              o_err     = ERR_ORDER;
              nxt_state = ST_ERR;
            end else begin
              modify        = 1'b1;
              mod_e.taken   = 1'b1;
              mod_e.in_else = 1'b1;
              nxt_active    = top.par & !top.taken;
            end
          end
          TK_ENDIF: begin
            if (depth == '0) begin
              o_err     = ERR_UNF;
              nxt_state = ST_ERR;
            end else begin
              pop        = 1'b1;
              nxt_active = top.par;
            end
          end
          default: o_active = cur_active;
        endcase
      end
    end
  end

  // Output register stage, FSM and defined table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid  <= 1'b0;
      bus.out_active <= 1'b0;
      bus.out_err    <= ERR_NONE;
      state          <= ST_RUN;
      cur_active     <= 1'b1;
      tbl            <= '0;
    end else begin
      if (bus.tok_ready) begin
        bus.out_valid <= bus.tok_valid;
      end
      if (accept) begin
        bus.out_active <= o_active;
        bus.out_err    <= o_err;
        state          <= nxt_state;
        cur_active     <= nxt_active;
      end
      // A clear pulse overrides a same-cycle DEFINE/UNDEF.
      if (bus.clr_defs) begin
        tbl <= '0;
      end else if (accept && state == ST_RUN && cur_active) begin
        if (kind == TK_DEFINE) begin
          tbl[bus.tok_id] <= 1'b1;
        end else if (kind == TK_UNDEF) begin
          tbl[bus.tok_id] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      bus.out_kind <= bus.tok_kind;
      bus.out_id   <= bus.tok_id;
    end
  end

endmodule

// File: tb/tb_cond_directive_sequencer.sv
module tb_cond_directive_sequencer;
  localparam int DEPTH = 8;
  localparam int ID_W  = 6;
  localparam int DW    = $clog2(DEPTH+1);

  typedef struct {
    int kind;
    int id;
    bit act;
    int err;
  } exp_t;

  logic clk;
  logic rst_n;
  logic [DW-1:0] depth;
  cond_directive_sequencer_if #(.ID_W(ID_W)) tif ();

  cond_directive_sequencer #(.DEPTH(DEPTH), .ID_W(ID_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (tif),
    .depth (depth)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   rdy_mode = 0;  // 0 always ready, 1 random, 2 never ready
  exp_t sb[$];

  // Reference model state
  bit m_tbl [64];
  bit m_par [DEPTH];
  bit m_taken [DEPTH];
  bit m_inelse [DEPTH];
  int m_depth;
  bit m_act;
  bit m_errst;

  task automatic model_clear();
    for (int i = 0; i < 64; i++) m_tbl[i] = 1'b0;
  endtask

  task automatic model_reset();
    model_clear();
    m_depth = 0;
    m_act   = 1'b1;
    m_errst = 1'b0;
  endtask

  task automatic model_step(input int k, input int id, output bit a, output int e);
    bit c;
    int t;
    a = 1'b0;
    e = 0;
    if (k == 8) begin
      a = 1'b1;
      e = (m_depth != 0) ? 4 : 0;
      m_depth = 0;
      m_act = 1'b1;
      m_errst = 1'b0;
      return;
    end
    if (m_errst) return;
    t = m_depth - 1;
    case (k)
      1, 2: begin
        c = (k == 2) ? !m_tbl[id] : m_tbl[id];
        if (m_depth == DEPTH) begin
          e = 1; m_errst = 1'b1;
        end else begin
          m_par[m_depth] = m_act;
          m_taken[m_depth] = c;
          m_inelse[m_depth] = 1'b0;
          m_depth++;
          m_act = m_act && c;
        end
      end
      3: begin
        if (m_depth == 0) begin e = 2; m_errst = 1'b1; end
        else if (m_inelse[t]) begin e = 3; m_errst = 1'b1; end
        else begin
          m_act = m_par[t] && !m_taken[t] && m_tbl[id];
          m_taken[t] = m_taken[t] || m_tbl[id];
        end
      end
      4: begin
        if (m_depth == 0) begin e = 2; m_errst = 1'b1; end
        else if (m_inelse[t]) begin e = 3; m_errst = 1'b1; end
        else begin
          m_act = m_par[t] && !m_taken[t];
          m_taken[t] = 1'b1;
          m_inelse[t] = 1'b1;
        end
      end
      5: begin
        if (m_depth == 0) begin e = 2; m_errst = 1'b1; end
        else begin
          m_depth--;
          m_act = m_par[m_depth];
        end
      end
      6: begin a = m_act; if (m_act) m_tbl[id] = 1'b1; end
      7: begin a = m_act; if (m_act) m_tbl[id] = 1'b0; end
      default: a = m_act;
    endcase
  endtask

  // Downstream ready generator
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: tif.out_ready = 1'b1;
      1: tif.out_ready = 1'($urandom_range(0, 1));
      default: tif.out_ready = 1'b0;
    endcase
  end

  // Output monitor: scoreboard compare on each transfer, hold check on stalls
  bit        stall_seen = 1'b0;
  logic [14:0] held;
  always @(negedge clk) begin
    exp_t e;
    logic [13:0] obs, req;
    if (!rst_n) begin
      stall_seen = 1'b0;
    end else begin
      if (stall_seen) begin
        checks++;
        assert ({tif.out_valid, tif.out_kind, tif.out_id, tif.out_active, tif.out_err} === held)
        else begin
          errors++;
          $error("FAIL stall_hold observed=%h expected=%h",
                 {tif.out_valid, tif.out_kind, tif.out_id, tif.out_active, tif.out_err}, held);
        end
      end
      if (tif.out_valid && tif.out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $error("FAIL unexpected_output observed kind=%0d id=%0d expected none", tif.out_kind, tif.out_id);
        end else begin
          e = sb.pop_front();
          obs = {tif.out_kind, tif.out_id, tif.out_active, tif.out_err};
          req = {4'(e.kind), 6'(e.id), e.act, 3'(e.err)};
          assert (obs === req)
          else begin
            errors++;
            $error("FAIL token observed kind=%0d id=%0d act=%0b err=%0d expected kind=%0d id=%0d act=%0b err=%0d",
                   tif.out_kind, tif.out_id, tif.out_active, tif.out_err, e.kind, e.id, e.act, e.err);
          end
        end
      end
      stall_seen = tif.out_valid && !tif.out_ready;
      held = {tif.out_valid, tif.out_kind, tif.out_id, tif.out_active, tif.out_err};
    end
  end

  // Drive one token; the model advances on the edge where it is accepted.
  task automatic send(input int k, input int id, input bit clr = 1'b0);
    int n = 0;
    bit acc = 1'b0;
    bit a;
    int e;
    tif.tok_valid = 1'b1;
    tif.tok_kind  = 4'(k);
    tif.tok_id    = 6'(id);
    tif.clr_defs  = clr;
    while (!acc && n < 1000) begin
      @(negedge clk);
      acc = tif.tok_ready;
      if (acc) begin
        model_step(k, id, a, e);
        sb.push_back('{k, id, a, e});
      end
      if (clr) model_clear();
      @(posedge clk);
      #1;
      n++;
    end
    tif.tok_valid = 1'b0;
    tif.clr_defs  = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $error("FAIL accept_timeout observed tok_ready=0 expected 1 within 1000 cycles");
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || tif.out_valid) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    assert (n < 500)
    else begin
      errors++;
      $error("FAIL drain_timeout observed pending=%0d expected 0", sb.size());
    end
  endtask

  task automatic check_depth(input string tag, input int exp);
    @(negedge clk);
    checks++;
    assert (depth === DW'(exp))
    else begin
      errors++;
      $error("FAIL %s observed depth=%0d expected %0d", tag, depth, exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed no finish expected finish before 500us");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    rst_n         = 1'b0;
    tif.tok_valid = 1'b0;
    tif.tok_kind  = '0;
    tif.tok_id    = '0;
    tif.clr_defs  = 1'b0;
    tif.out_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    assert ({tif.out_valid, tif.out_active, tif.out_err, tif.tok_ready} === 6'b000001)
    else begin
      errors++;
      $error("FAIL reset_outputs observed v=%0b a=%0b e=%0d r=%0b expected 0 0 0 1",
             tif.out_valid, tif.out_active, tif.out_err, tif.tok_ready);
    end
    checks++;
    assert (depth === '0)
    else begin errors++; $error("FAIL reset_depth observed %0d expected 0", depth); end
    rst_n = 1'b1;
    idle(1);

    // defined macro: if-branch active, else-branch inactive
    send(6, 5); send(1, 5); send(0, 0); send(4, 0); send(0, 0); send(5, 0);
    drain();
    check_depth("depth_after_ifdef_else", 0);

    // IFNDEF of undefined id, ELSIF undefined, ELSE
    send(2, 3); send(0, 0); send(3, 4); send(0, 0); send(4, 0); send(0, 0); send(5, 0);
    send(1, 3); send(0, 0); send(3, 4); send(0, 0); send(4, 0); send(0, 0); send(5, 0);
    drain();
    check_depth("depth_after_elsif", 0);

    // overflow on the ninth nested IFDEF
    for (int i = 0; i < 9; i++) send(1, 5);
    drain();
    check_depth("depth_at_overflow", DEPTH);
    send(0, 0); send(6, 9); send(8, 0);
    drain();
    check_depth("depth_after_eof_ovf", 0);

    // underflow, double ELSE, unterminated
    send(5, 0); send(0, 0); send(8, 0);
    send(1, 5); send(4, 0); send(4, 0); send(0, 0); send(8, 0);
    send(1, 5); send(0, 0); send(8, 0);
    drain();
    check_depth("depth_after_errors", 0);

    // DEFINE inside an inactive branch has no effect
    send(1, 5); send(4, 0); send(6, 7); send(5, 0);
    send(1, 7); send(0, 0); send(5, 0);
    // clear pulse wins over a same-cycle DEFINE
    send(6, 10, 1'b1); send(1, 10); send(0, 0); send(5, 0);
    // standalone clear
    tif.clr_defs = 1'b1;
    @(posedge clk);
    #1;
    tif.clr_defs = 1'b0;
    model_clear();
    send(1, 5); send(0, 0); send(5, 0);
    drain();

    // reset while an output token is stalled
    send(6, 9); send(1, 9);
    drain();
    rdy_mode = 2;
    idle(1);
    send(0, 0);
    idle(2);
    checks++;
    assert (tif.out_valid === 1'b1)
    else begin errors++; $error("FAIL stalled_valid observed %0b expected 1", tif.out_valid); end
    rst_n = 1'b0;
    #1;
    checks++;
    assert ({tif.out_valid, tif.out_active, tif.out_err, depth} === {1'b0, 1'b0, 3'd0, DW'(0)})
    else begin
      errors++;
      $error("FAIL midreset observed v=%0b a=%0b e=%0d d=%0d expected 0 0 0 0",
             tif.out_valid, tif.out_active, tif.out_err, depth);
    end
    sb.delete();
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rdy_mode = 0;
    idle(1);
    send(1, 9); send(0, 0); send(5, 0);
    drain();

    // random stream with 50% downstream stalls
    rdy_mode = 1;
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 99);
      if      (r < 40) send(0, 0);
      else if (r < 52) send(1, $urandom_range(0, 7));
      else if (r < 60) send(2, $urandom_range(0, 7));
      else if (r < 66) send(3, $urandom_range(0, 7));
      else if (r < 74) send(4, 0);
      else if (r < 86) send(5, 0);
      else if (r < 92) send(6, $urandom_range(0, 7));
      else if (r < 97) send(7, $urandom_range(0, 7));
      else             send(8, 0);
    end
    send(8, 0);
    drain();
    rdy_mode = 0;
    idle(1);
    check_depth("depth_after_random", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
